// File: rtl/debug_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// debug_frame_serializer_if : frame valid/ready bus between serializer and framer
// Rev 1.0
// ============================================================================
interface debug_frame_serializer_if #(
    parameter int NB_LATCH = 32,
    parameter int NB_IDX   = 1
);
    logic [NB_LATCH-1:0] o_frame_to_interface;
    logic                o_writing;
    logic [NB_IDX-1:0]   o_frame_index;
    logic                i_interface_ready;

    modport master (
        output o_frame_to_interface,
        output o_writing,
        output o_frame_index,
        input  i_interface_ready
    );

    modport slave (
        input  o_frame_to_interface,
        input  o_writing,
        input  o_frame_index,
        output i_interface_ready
    );
endinterface
`default_nettype wire

// File: rtl/debug_frame_serializer.sv
`default_nettype none
// ============================================================================
// debug_frame_serializer : snapshots one of N debug channels, emits it MSB-first
// as NB_LATCH-bit frames under valid/ready with abort and done pulse.
// Rev 1.0
// ============================================================================
module debug_frame_serializer #(
    parameter int         NB_LATCH      = 32,
    parameter int         NB_INPUT_SIZE = 32,
    parameter int         N_CHANNELS    = 4,
    parameter logic [5:0] CONTROLLER_ID = 6'h00
) (
    input  wire logic                               i_clock,
    input  wire logic                               i_reset,
    input  wire logic [5:0]                         i_request_select,
    input  wire logic [N_CHANNELS*NB_INPUT_SIZE-1:0] i_data_from_mips,
    input  wire logic                               i_abort,
    output logic                                    o_busy,
    output logic                                    o_done,
    debug_frame_serializer_if.master                frame_bus
);
    localparam int c_n_frames = (NB_INPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
    localparam int c_nb_shift = c_n_frames * NB_LATCH;
    localparam int c_nb_pad   = c_nb_shift - NB_INPUT_SIZE;
    localparam int c_nb_idx   = (c_n_frames > 1) ? $clog2(c_n_frames) : 1;
    localparam logic [c_nb_idx-1:0] c_last_idx = c_nb_idx'(c_n_frames - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_nb_shift-1:0]   r_shift;
    logic [c_nb_idx-1:0]     r_idx;
    logic [NB_LATCH-1:0]     r_frame;
    logic                    r_writing;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_prev_match;
    logic [5:0]              r_prev_sel;

    logic [6:0]              w_sel_ext;
    logic                    w_match;
    logic [5:0]              w_chan;
    logic                    w_new_req;
    logic [NB_INPUT_SIZE-1:0] w_chan_data;
    logic [c_nb_shift-1:0]   w_capture;
    logic [c_nb_shift-1:0]   w_shift_next;

    // Range check done in 7 bits so CONTROLLER_ID+N_CHANNELS cannot wrap.
    assign w_sel_ext = {1'b0, i_request_select};
    assign w_match   = (w_sel_ext >= {1'b0, CONTROLLER_ID}) &&
                       (w_sel_ext <  ({1'b0, CONTROLLER_ID} + 7'(N_CHANNELS)));
    assign w_chan    = i_request_select - CONTROLLER_ID;
    assign w_new_req = w_match && (!r_prev_match || (i_request_select != r_prev_sel));

    always_comb begin
        w_chan_data = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (w_chan == 6'(k)) begin
                w_chan_data = i_data_from_mips[k*NB_INPUT_SIZE +: NB_INPUT_SIZE];
            end
        end
    end

    // Channel word sits at the MSB end; pad zeros fill the tail of the last frame.
    assign w_capture    = c_nb_shift'(w_chan_data) << c_nb_pad;
    assign w_shift_next = r_shift << NB_LATCH;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_frame      <= '0;
            r_writing    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_prev_match <= 1'b0;
            r_prev_sel   <= '0;
        end else begin
            r_prev_match <= w_match;
            r_prev_sel   <= i_request_select;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_new_req) begin
                        r_state   <= S_SEND;
                        r_shift   <= w_capture;
                        r_idx     <= '0;
                        r_frame   <= w_capture[c_nb_shift-1 -: NB_LATCH];
                        r_writing <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_shift   <= '0;
                        r_idx     <= '0;
                        r_frame   <= '0;
                        r_writing <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (frame_bus.i_interface_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state   <= S_DONE;
                            r_frame   <= '0;
                            r_writing <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_shift <= w_shift_next;
                            r_frame <= w_shift_next[c_nb_shift-1 -: NB_LATCH];
                            r_idx   <= r_idx + c_nb_idx'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    if (i_abort) begin
                        r_shift <= '0;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_writing <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_frame   <= '0;
                end
            endcase
        end
    end

    assign frame_bus.o_frame_to_interface = r_frame;
    assign frame_bus.o_writing            = r_writing;
    assign frame_bus.o_frame_index        = r_idx;
    assign o_busy                         = r_busy;
    assign o_done                         = r_done;
endmodule
`default_nettype wire
